// File: rtl/decode_stage.sv
// MIPS instruction-decode stage: decodes IF/ID, bypasses writeback over RF read data,
// detects load-use hazards against ID/EX and registers the decoded result into ID/EX.
module decode_stage #(
    parameter bit WB_BYPASS = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_valid,
    input  logic [31:0] if_instr,
    input  logic [31:0] if_pc4,
    output logic [4:0]  rf_raddr1,
    output logic [4:0]  rf_raddr2,
    input  logic [31:0] rf_rdata1,
    input  logic [31:0] rf_rdata2,
    input  logic        wb_regwrite,
    input  logic [4:0]  wb_waddr,
    input  logic [31:0] wb_wdata,
    input  logic        ex_flush,
    output logic        stall_id,
    output logic        ex_valid,
    output logic [31:0] ex_pc4,
    output logic [31:0] ex_rs_data,
    output logic [31:0] ex_rt_data,
    output logic [31:0] ex_imm,
    output logic [4:0]  ex_rs,
    output logic [4:0]  ex_rt,
    output logic [4:0]  ex_rd,
    output logic [4:0]  ex_shamt,
    output logic [3:0]  ex_alu_op,
    output logic        ex_alu_src,
    output logic        ex_mem_read,
    output logic        ex_mem_write,
    output logic        ex_reg_write,
    output logic        ex_mem_to_reg,
    output logic        ex_beq,
    output logic        ex_bne,
    output logic        ex_illegal
);

    localparam logic [5:0] OpRtype = 6'h00;
    localparam logic [5:0] OpBeq   = 6'h04;
    localparam logic [5:0] OpBne   = 6'h05;
    localparam logic [5:0] OpAddi  = 6'h08;
    localparam logic [5:0] OpAddiu = 6'h09;
    localparam logic [5:0] OpSlti  = 6'h0A;
    localparam logic [5:0] OpSltiu = 6'h0B;
    localparam logic [5:0] OpAndi  = 6'h0C;
    localparam logic [5:0] OpOri   = 6'h0D;
    localparam logic [5:0] OpXori  = 6'h0E;
    localparam logic [5:0] OpLui   = 6'h0F;
    localparam logic [5:0] OpLw    = 6'h23;
    localparam logic [5:0] OpSw    = 6'h2B;

    localparam logic [3:0] AluAdd  = 4'd0;
    localparam logic [3:0] AluSub  = 4'd1;
    localparam logic [3:0] AluAnd  = 4'd2;
    localparam logic [3:0] AluOr   = 4'd3;
    localparam logic [3:0] AluXor  = 4'd4;
    localparam logic [3:0] AluNor  = 4'd5;
    localparam logic [3:0] AluSlt  = 4'd6;
    localparam logic [3:0] AluSltu = 4'd7;
    localparam logic [3:0] AluSll  = 4'd8;
    localparam logic [3:0] AluSrl  = 4'd9;
    localparam logic [3:0] AluSra  = 4'd10;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc4;
        logic [31:0] rs_data;
        logic [31:0] rt_data;
        logic [31:0] imm;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [4:0]  shamt;
        logic [3:0]  alu_op;
        logic        alu_src;
        logic        mem_read;
        logic        mem_write;
        logic        reg_write;
        logic        mem_to_reg;
        logic        beq;
        logic        bne;
        logic        illegal;
    } id_ex_t;

    id_ex_t id_ex_d, id_ex_q;

    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [4:0]  rs_f, rt_f, rd_f;
    logic [31:0] sext_imm, zext_imm;

    logic [31:0] dec_imm;
    logic [4:0]  dec_dest;
    logic [4:0]  dec_shamt;
    logic [3:0]  dec_alu_op;
    logic        dec_alu_src;
    logic        dec_mem_read;
    logic        dec_mem_write;
    logic        dec_mem_to_reg;
    logic        dec_beq;
    logic        dec_bne;
    logic        dec_writes;
    logic        dec_illegal;
    logic        rs_used;
    logic        rt_used;

    logic        rs_bypass, rt_bypass;
    logic [31:0] rs_data, rt_data;
    logic        load_use;

    assign opcode   = if_instr[31:26];
    assign rs_f     = if_instr[25:21];
    assign rt_f     = if_instr[20:16];
    assign rd_f     = if_instr[15:11];
    assign funct    = if_instr[5:0];
    assign sext_imm = {{16{if_instr[15]}}, if_instr[15:0]};
    assign zext_imm = {16'h0000, if_instr[15:0]};

    assign rf_raddr1 = rs_f;
    assign rf_raddr2 = rt_f;

    always_comb begin
        dec_imm        = 32'h0;
        dec_dest       = 5'd0;
        dec_shamt      = 5'd0;
        dec_alu_op     = AluAdd;
        dec_alu_src    = 1'b0;
        dec_mem_read   = 1'b0;
        dec_mem_write  = 1'b0;
        dec_mem_to_reg = 1'b0;
        dec_beq        = 1'b0;
        dec_bne        = 1'b0;
        dec_writes     = 1'b0;
        dec_illegal    = 1'b0;
        rs_used        = 1'b1;
        rt_used        = 1'b0;

        case (opcode)
            OpRtype: begin
                dec_dest   = rd_f;
                dec_shamt  = if_instr[10:6];
                dec_writes = 1'b1;
                rt_used    = 1'b1;
                case (funct)
                    6'h00: begin dec_alu_op = AluSll; rs_used = 1'b0; end
                    6'h02: begin dec_alu_op = AluSrl; rs_used = 1'b0; end
                    6'h03: begin dec_alu_op = AluSra; rs_used = 1'b0; end
                    6'h20, 6'h21: dec_alu_op = AluAdd;
                    6'h22, 6'h23: dec_alu_op = AluSub;
                    6'h24: dec_alu_op = AluAnd;
                    6'h25: dec_alu_op = AluOr;
                    6'h26: dec_alu_op = AluXor;
                    6'h27: dec_alu_op = AluNor;
                    6'h2A: dec_alu_op = AluSlt;
                    6'h2B: dec_alu_op = AluSltu;
                    default: dec_illegal = 1'b1;
                endcase
            end
            OpAddi, OpAddiu, OpSlti, OpSltiu, OpAndi, OpOri, OpXori, OpLui: begin
                dec_dest    = rt_f;
                dec_writes  = 1'b1;
                dec_alu_src = 1'b1;
                dec_imm     = sext_imm;
                case (opcode)
                    OpSlti:  dec_alu_op = AluSlt;
                    OpSltiu: dec_alu_op = AluSltu;
                    OpAndi:  begin dec_alu_op = AluAnd; dec_imm = zext_imm; end
                    OpOri:   begin dec_alu_op = AluOr;  dec_imm = zext_imm; end
                    OpXori:  begin dec_alu_op = AluXor; dec_imm = zext_imm; end
                    OpLui:   dec_imm = {if_instr[15:0], 16'h0000};
                    default: dec_alu_op = AluAdd;
                endcase
            end
            OpLw: begin
                dec_dest       = rt_f;
                dec_writes     = 1'b1;
                dec_alu_src    = 1'b1;
                dec_imm        = sext_imm;
                dec_mem_read   = 1'b1;
                dec_mem_to_reg = 1'b1;
            end
            OpSw: begin
                dec_alu_src   = 1'b1;
                dec_imm       = sext_imm;
                dec_mem_write = 1'b1;
                rt_used       = 1'b1;
            end
            OpBeq, OpBne: begin
                dec_alu_op = AluSub;
                dec_imm    = sext_imm;
                dec_beq    = (opcode == OpBeq);
                dec_bne    = (opcode == OpBne);
                rt_used    = 1'b1;
            end
            default: dec_illegal = 1'b1;
        endcase

        // Illegal instructions still travel down the pipe but carry no side effects.
        if (dec_illegal) begin
            dec_imm        = 32'h0;
            dec_dest       = 5'd0;
            dec_shamt      = 5'd0;
            dec_alu_op     = AluAdd;
            dec_alu_src    = 1'b0;
            dec_mem_read   = 1'b0;
            dec_mem_write  = 1'b0;
            dec_mem_to_reg = 1'b0;
            dec_beq        = 1'b0;
            dec_bne        = 1'b0;
            dec_writes     = 1'b0;
            rs_used        = 1'b0;
            rt_used        = 1'b0;
        end
    end

    assign rs_bypass = WB_BYPASS && wb_regwrite && (wb_waddr != 5'd0) && (wb_waddr == rs_f);
    assign rt_bypass = WB_BYPASS && wb_regwrite && (wb_waddr != 5'd0) && (wb_waddr == rt_f);
    assign rs_data   = rs_bypass ? wb_wdata : rf_rdata1;
    assign rt_data   = rt_bypass ? wb_wdata : rf_rdata2;

    assign load_use = id_ex_q.valid && id_ex_q.mem_read && (id_ex_q.rd != 5'd0) &&
                      ((rs_used && (rs_f == id_ex_q.rd)) || (rt_used && (rt_f == id_ex_q.rd)));
    assign stall_id = load_use && if_valid && !ex_flush;

    always_comb begin
        id_ex_d = '0;
        if (!ex_flush && !stall_id && if_valid) begin
            id_ex_d.valid      = 1'b1;
            id_ex_d.pc4        = if_pc4;
            id_ex_d.rs_data    = rs_data;
            id_ex_d.rt_data    = rt_data;
            id_ex_d.imm        = dec_imm;
            id_ex_d.rs         = rs_f;
            id_ex_d.rt         = rt_f;
            id_ex_d.rd         = dec_dest;
            id_ex_d.shamt      = dec_shamt;
            id_ex_d.alu_op     = dec_alu_op;
            id_ex_d.alu_src    = dec_alu_src;
            id_ex_d.mem_read   = dec_mem_read;
            id_ex_d.mem_write  = dec_mem_write;
            id_ex_d.reg_write  = dec_writes && (dec_dest != 5'd0);
            id_ex_d.mem_to_reg = dec_mem_to_reg;
            id_ex_d.beq        = dec_beq;
            id_ex_d.bne        = dec_bne;
            id_ex_d.illegal    = dec_illegal;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            id_ex_q <= '0;
        end else begin
            id_ex_q <= id_ex_d;
        end
    end

    assign ex_valid      = id_ex_q.valid;
    assign ex_pc4        = id_ex_q.pc4;
    assign ex_rs_data    = id_ex_q.rs_data;
    assign ex_rt_data    = id_ex_q.rt_data;
    assign ex_imm        = id_ex_q.imm;
    assign ex_rs         = id_ex_q.rs;
    assign ex_rt         = id_ex_q.rt;
    assign ex_rd         = id_ex_q.rd;
    assign ex_shamt      = id_ex_q.shamt;
    assign ex_alu_op     = id_ex_q.alu_op;
    assign ex_alu_src    = id_ex_q.alu_src;
    assign ex_mem_read   = id_ex_q.mem_read;
    assign ex_mem_write  = id_ex_q.mem_write;
    assign ex_reg_write  = id_ex_q.reg_write;
    assign ex_mem_to_reg = id_ex_q.mem_to_reg;
    assign ex_beq        = id_ex_q.beq;
    assign ex_bne        = id_ex_q.bne;
    assign ex_illegal    = id_ex_q.illegal;

endmodule
